// File: rtl/store_unit.sv
// Store buffer between the pipeline and data memory: formats byte/half/word stores
// into lane-replicated data plus byte strobes and queues them. Optional: STORE_MISALIGN_CHECK_EN.
module store_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        busy,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;

  logic            w_full, w_empty, w_accept, w_push, w_pop, w_mis;
  logic [3:0][7:0] w_lane;
  logic [3:0]      w_strb;
  entry_t          w_entry, w_head;

  // Each byte lane picks the source byte that a store of this size would place there.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    always_comb begin
      w_lane[i] = req_data[8*i +: 8];
      case (req_size)
        2'b00:   w_lane[i] = req_data[7:0];
        2'b01:   w_lane[i] = req_data[8*(i%2) +: 8];
        default: w_lane[i] = req_data[8*i +: 8];
      endcase
    end
  end

  always_comb begin
    w_strb = 4'b1111;
    case (req_size)
      2'b00:   w_strb = 4'b0001 << req_addr[1:0];
      2'b01:   w_strb = req_addr[1] ? 4'b1100 : 4'b0011;
      default: w_strb = 4'b1111;
    endcase
  end

`ifdef STORE_MISALIGN_CHECK_EN
  assign w_mis = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign req_ready = !w_full;
  assign mem_valid = !w_empty;
  assign busy      = mem_valid;

  // Reserved sizes and flagged misaligned stores complete the handshake but never queue.
  assign w_accept = req_valid && req_ready;
  assign w_push   = w_accept && (req_size != 2'b11) && !w_mis;
  assign w_pop    = mem_valid && mem_ready;

  assign w_entry = '{addr: {req_addr[31:2], 2'b00}, wdata: w_lane, wstrb: w_strb};
  assign w_head  = r_mem[r_rptr];

  assign mem_addr  = w_empty ? 32'h0 : w_head.addr;
  assign mem_wdata = w_empty ? 32'h0 : w_head.wdata;
  assign mem_wstrb = w_empty ? 4'h0  : w_head.wstrb;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef STORE_MISALIGN_CHECK_EN
  logic r_misalign;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_accept && w_mis;
  end
  assign misalign = r_misalign;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_store_unit.sv
// Table-driven scoreboard bench for store_unit: expected writes queue at acceptance
// and are compared when memory takes them; plus backpressure and reset corner cases.
module tb_store_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        busy, misalign;

  store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .busy(busy), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [3:0]  estrb;
    logic        enq;
    logic        mis;
  } vec_t;

  vec_t tbl[11];
  vec_t bp[3];
  vec_t q[$];
  vec_t idle;
  int   checks = 0;
  int   failures = 0;
  logic pend_mis = 1'b0;

  function automatic vec_t mk(logic [31:0] a, logic [31:0] d, logic [1:0] s,
                              logic [31:0] ea, logic [31:0] ew, logic [3:0] es,
                              logic en, logic m);
    vec_t v;
    v.addr = a; v.data = d; v.size = s; v.eaddr = ea; v.ewdata = ew;
    v.estrb = es; v.enq = en; v.mis = m;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_data  = v.data;
    req_size  = v.size;
  endtask

  // One clock: check outputs at the negedge against the model, then book the handshakes.
  task automatic step(input vec_t e, output logic acc);
    vec_t h;
    logic room;
    @(negedge clk);
    room = (q.size() < DEPTH);
    chk("mem_valid", {31'b0, mem_valid}, {31'b0, q.size() != 0});
    chk("busy", {31'b0, busy}, {31'b0, q.size() != 0});
    chk("req_ready", {31'b0, req_ready}, {31'b0, room});
    chk("misalign", {31'b0, misalign}, {31'b0, pend_mis});
    if (q.size() == 0) begin
      chk("idle_addr", mem_addr, 32'h0);
      chk("idle_strb", {28'b0, mem_wstrb}, 32'h0);
    end
    if (mem_ready && q.size() != 0) begin
      h = q.pop_front();
      chk("mem_addr", mem_addr, h.eaddr);
      chk("mem_wdata", mem_wdata, h.ewdata);
      chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, h.estrb});
    end
    acc = req_valid && room;
    pend_mis = acc && e.mis;
    if (acc && e.enq) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    req_valid = 1'b0;
    for (int i = 0; i < 12 && q.size() != 0; i++) step(idle, acc);
    step(idle, acc);
    chk("drained", q.size(), 0);
  endtask

  initial begin
    logic acc;
    int   tries;
    idle = mk(0, 0, 2'b00, 0, 0, 4'h0, 1'b0, 1'b0);
    tbl[0]  = mk(32'h1003, 32'h000000AB, 2'b00, 32'h1000, 32'hABABABAB, 4'b1000, 1, 0);
    tbl[1]  = mk(32'h2002, 32'h1234CAFE, 2'b01, 32'h2000, 32'hCAFECAFE, 4'b1100, 1, 0);
    tbl[2]  = mk(32'h2004, 32'hDEADBEEF, 2'b10, 32'h2004, 32'hDEADBEEF, 4'b1111, 1, 0);
    tbl[3]  = mk(32'h0040, 32'h12345678, 2'b00, 32'h0040, 32'h78787878, 4'b0001, 1, 0);
    tbl[4]  = mk(32'h0041, 32'h0000009C, 2'b00, 32'h0040, 32'h9C9C9C9C, 4'b0010, 1, 0);
    tbl[5]  = mk(32'h0042, 32'hFFFFFF5A, 2'b00, 32'h0040, 32'h5A5A5A5A, 4'b0100, 1, 0);
    tbl[6]  = mk(32'h0050, 32'hFFFF0001, 2'b01, 32'h0050, 32'h00010001, 4'b0011, 1, 0);
    tbl[7]  = mk(32'h0060, 32'h55555555, 2'b11, 32'h0, 32'h0, 4'h0, 0, 0);
`ifdef STORE_MISALIGN_CHECK_EN
    tbl[8]  = mk(32'h3001, 32'h0000BEEF, 2'b01, 32'h0, 32'h0, 4'h0, 0, 1);
    tbl[9]  = mk(32'h3006, 32'h11223344, 2'b10, 32'h0, 32'h0, 4'h0, 0, 1);
    tbl[10] = mk(32'h3003, 32'h00007777, 2'b01, 32'h0, 32'h0, 4'h0, 0, 1);
`else
    tbl[8]  = mk(32'h3001, 32'h0000BEEF, 2'b01, 32'h3000, 32'hBEEFBEEF, 4'b0011, 1, 0);
    tbl[9]  = mk(32'h3006, 32'h11223344, 2'b10, 32'h3004, 32'h11223344, 4'b1111, 1, 0);
    tbl[10] = mk(32'h3003, 32'h00007777, 2'b01, 32'h3000, 32'h77777777, 4'b1100, 1, 0);
`endif
    bp[0] = mk(32'h4000, 32'hA0A0A0A0, 2'b10, 32'h4000, 32'hA0A0A0A0, 4'b1111, 1, 0);
    bp[1] = mk(32'h4005, 32'h000000B1, 2'b00, 32'h4004, 32'hB1B1B1B1, 4'b0010, 1, 0);
    bp[2] = mk(32'h400A, 32'h0000C2C2, 2'b01, 32'h4008, 32'hC2C2C2C2, 4'b1100, 1, 0);

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    mem_ready = 1'b1;
    #12;
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back stores with memory always ready.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i]);
      step(tbl[i], acc);
      chk("tbl_accept", {31'b0, acc}, 32'h1);
    end
    drain();

    // Backpressure: two fill the buffer, the third waits until memory drains.
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(bp[i]);
      step(bp[i], acc);
      chk("bp_accept", {31'b0, acc}, 32'h1);
    end
    drive(bp[2]);
    for (int i = 0; i < 3; i++) begin
      step(bp[2], acc);
      chk("bp_held", {31'b0, acc}, 32'h0);
    end
    mem_ready = 1'b1;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 6) begin
      step(bp[2], acc);
      tries++;
    end
    chk("bp_third_accept", {31'b0, acc}, 32'h1);
    drain();

    // Reset while a write is stalled mid-handshake.
    mem_ready = 1'b0;
    drive(tbl[2]);
    step(tbl[2], acc);
    req_valid = 1'b0;
    step(idle, acc);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'b0, mem_valid}, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_mid_addr", mem_addr, 32'h0);
    q.delete();
    pend_mis = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    drive(tbl[0]);
    step(tbl[0], acc);
    chk("post_rst_accept", {31'b0, acc}, 32'h1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of store-buffer entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a store.
REQ-005 SHALL have port req_ready  output  1  unit can accept a store this cycle.
REQ-006 SHALL have port req_addr  input  32  byte address of the store.
REQ-007 SHALL have port req_data  input  32  store data, right-justified.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port mem_valid  output  1  write presented to data memory.
REQ-010 SHALL have port mem_ready  input  1  data memory accepts the write.
REQ-011 SHALL have port mem_addr  output  32  word address, bits [1:0] always 0.
REQ-012 SHALL have port mem_wdata  output  32  lane-replicated write data.
REQ-013 SHALL have port mem_wstrb  output  4  byte-lane write strobes.
REQ-014 SHALL have port busy  output  1  buffer non-empty.
REQ-015 SHALL have port misalign  output  1  one-cycle misaligned-store flag.

Function
REQ-016 SHALL accept a request when req_valid && req_ready; req_ready = buffer not full (no same-cycle pop bypass).
REQ-017 SHALL enqueue accepted stores in FIFO order; head drives mem_* registered; mem_valid = buffer not empty.
REQ-018 SHALL pop the head when mem_valid && mem_ready; push and pop in same cycle SHALL both occur, count unchanged.
REQ-019 SHALL present a store accepted into an empty buffer on mem_* the next cycle (latency 1).
REQ-020 SHALL hold mem_addr/mem_wdata/mem_wstrb stable while mem_valid && !mem_ready.
REQ-021 Byte: wdata = data[7:0] replicated x4; wstrb = 4'b0001 << addr[1:0].
REQ-022 Half: wdata = data[15:0] replicated x2; wstrb = 4'b0011 << (2*addr[1]).
REQ-023 Word: wdata = data; wstrb = 4'b1111.
REQ-024 Reserved size (11): SHALL be accepted and discarded, never enqueued.
REQ-025 mem_addr = {req_addr[31:2], 2'b00} captured at acceptance.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; full/empty distinguished by an extra pointer bit or count.
REQ-027 busy SHALL equal mem_valid.

Reset
REQ-028 rst high SHALL immediately empty the buffer, discarding in-flight entries, including one mid-handshake.
REQ-029 During and after reset: mem_valid=0, busy=0, misalign=0, req_ready=1, mem_addr/mem_wdata/mem_wstrb=0.

Configuration
REQ-030 Macro STORE_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL be accepted, not enqueued, and misalign SHALL pulse high exactly one cycle after acceptance.
REQ-031 Macro undefined: misalign SHALL be constant 0; address low bits not used by REQ-021..023 SHALL be ignored and the store enqueued.

Verification
REQ-032 Byte addr 0x1003 data 0x000000AB, mem_ready=1 -> next cycle mem_addr 0x1000, wdata 0xABABABAB, wstrb 1000.
REQ-033 Half addr 0x2002 data 0x1234CAFE -> wdata 0xCAFECAFE, wstrb 1100; word addr 0x2004 -> wstrb 1111.
REQ-034 mem_ready=0, DEPTH=2, three back-to-back stores -> req_ready low after two; raise mem_ready -> drain in issue order, third accepted.
REQ-035 Half addr 0x3001: with macro -> misalign pulse one cycle, no mem_valid; without -> wstrb 0011 issued, misalign 0.
REQ-036 Assert rst while mem_valid=1 and mem_ready=0 -> mem_valid, busy drop same cycle; post-reset store issues normally.
